// File: rtl/array_32_port_ctrl.sv
// -----------------------------------------------------------------------------
// array_32_port_ctrl
//
// Sequencer and arbiter for a single-port DEPTH x DATA_W masked SRAM
// (one RW port, MASK_W write-enable bits, one per DATA_W/MASK_W-bit granule).
//
// After reset the block sweeps every entry to INIT_VAL, one write per cycle.
// Once the sweep completes it shares the RW port between a write requester
// and a read requester, granting at most one of them per cycle with
// round-robin arbitration on conflicts. Read data comes back as a single
// cycle pulse on resp_valid/resp_data the cycle after the read is granted.
//
// Ports
//   clock       in   1       sole clock, all state on posedge
//   reset       in   1       synchronous, active-high
//   init_done   out  1       1 once the init sweep has completed
//   w_valid     in   1       write request
//   w_ready     out  1       write accepted when w_valid && w_ready
//   w_addr      in   ADDR_W  write address
//   w_mask      in   MASK_W  per-granule write enable
//   w_data      in   DATA_W  write data
//   r_valid     in   1       read request
//   r_ready     out  1       read accepted when r_valid && r_ready
//   r_addr      in   ADDR_W  read address
//   resp_valid  out  1       read data valid, one pulse per accepted read
//   resp_data   out  DATA_W  read data (don't-care when resp_valid=0)
//   mem_en      out  1       SRAM enable
//   mem_wmode   out  1       SRAM 1=write, 0=read
//   mem_addr    out  ADDR_W  SRAM address
//   mem_wmask   out  MASK_W  SRAM write mask
//   mem_wdata   out  DATA_W  SRAM write data
//   mem_rdata   in   DATA_W  SRAM read data, valid the cycle after a read
//   state_dbg   out  1       controller state: 0=INIT sweep, 1=RUN
//
// Handshake: a transfer happens in every cycle where valid && ready are both
// high. ready is a combinational function of the valids and the arbitration
// state; a requester must hold its valid (and payload) stable until accepted
// and must never make valid depend on ready. The response channel has no
// ready: responses cannot be back-pressured.
// -----------------------------------------------------------------------------
module array_32_port_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int DATA_W = 36,
  parameter int MASK_W = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              state_dbg
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Which side won the most recent conflict. The other side wins the next one.
  typedef enum logic {
    SIDE_READ  = 1'b0,
    SIDE_WRITE = 1'b1
  } side_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  side_t             rr_last, rr_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              grant_w, grant_r;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      rr_last    <= SIDE_WRITE;   // read is favoured at the first conflict
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rr_last    <= rr_nxt;
      // SRAM read data lands one cycle after the read enable.
      resp_valid <= grant_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, arbitration and SRAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_last;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;

    unique case (state)
      ST_INIT: begin
        // Full-mask write of INIT_VAL to the entry under the sweep counter.
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = cnt;
        mem_wmask = '1;
        mem_wdata = INIT_VAL;
        if (cnt == LAST_ADDR) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end

      ST_RUN: begin
        if (w_valid && r_valid) begin
          // Conflict: alternate, and remember who won.
          if (rr_last == SIDE_WRITE) begin
            grant_r = 1'b1;
            rr_nxt  = SIDE_READ;
          end else begin
            grant_w = 1'b1;
            rr_nxt  = SIDE_WRITE;
          end
        end else begin
          grant_w = w_valid;
          grant_r = r_valid;
        end

        if (grant_w) begin
          // A zero mask still consumes the port; the array is left unchanged.
          mem_en    = 1'b1;
          mem_wmode = 1'b1;
          mem_addr  = w_addr;
          mem_wmask = w_mask;
          mem_wdata = w_data;
        end else if (grant_r) begin
          mem_en    = 1'b1;
          mem_wmode = 1'b0;
          mem_addr  = r_addr;
        end
      end

      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_ready   = grant_w;
  assign r_ready   = grant_r;
  assign init_done = (state == ST_RUN);
  assign resp_data = mem_rdata;
  assign state_dbg = state;

endmodule

// File: tb/tb_array_32_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_array_32_port_ctrl
//
// Bench for array_32_port_ctrl. Holds a behavioural SRAM attached to the mem_*
// port, plus a reference array (ref_mem) updated on every accepted write and
// an expected-response queue filled on every accepted read. Arbitration is
// predicted from the rule "on a conflict, the side that did not win the
// previous conflict wins; read wins the first one".
// -----------------------------------------------------------------------------
module tb_array_32_port_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 36;
  localparam int MASK_W = 6;
  localparam int GW     = DATA_W / MASK_W;
  localparam logic [DATA_W-1:0] INIT_VAL = '0;

  logic              clock;
  logic              reset;
  logic              init_done;
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [MASK_W-1:0] w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              mem_en;
  logic              mem_wmode;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              state_dbg;

  array_32_port_ctrl #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .MASK_W  (MASK_W),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .init_done (init_done),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_addr    (w_addr),
    .w_mask    (w_mask),
    .w_data    (w_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_addr    (r_addr),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .mem_en    (mem_en),
    .mem_wmode (mem_wmode),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural SRAM macro
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sram [DEPTH];

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int g = 0; g < MASK_W; g++)
          if (mem_wmask[g]) sram[mem_addr][g*GW +: GW] <= mem_wdata[g*GW +: GW];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / reference state
  // ---------------------------------------------------------------------------
  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  bit                resp_due;
  bit                favour_read;
  bit                last_gw, last_gr;
  int                resp_seen;
  logic [DATA_W-1:0] last_resp;
  string             grants;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    w_valid = 1'b0;
    r_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    resp_due    = 1'b0;
    favour_read = 1'b1;
    exp_q.delete();
  endtask

  // n cycles of the init sweep, starting from sweep address 'start'
  task automatic sweep(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("sweep",
            {init_done, w_ready, r_ready, mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata, resp_valid},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'(start + i), 6'h3F, INIT_VAL, 1'b0});
      @(posedge clock);
      #1;
    end
    if (start + n == DEPTH)
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = INIT_VAL;
  endtask

  // One RUN-state cycle with the currently driven requests.
  task automatic run_cycle();
    bit gw, gr;
    @(negedge clock);
    check("init_done", init_done, 1);
    if (resp_valid === 1'b1) begin
      resp_seen++;
      last_resp = resp_data;
    end
    if (resp_due) begin
      check("resp_valid", resp_valid, 1);
      if (exp_q.size() > 0) check("resp_data", resp_data, exp_q.pop_front());
    end else begin
      check("resp_valid", resp_valid, 0);
    end

    if (w_valid && r_valid) begin
      gr          = favour_read;
      gw          = !favour_read;
      favour_read = !favour_read;
    end else begin
      gw = w_valid;
      gr = r_valid;
    end
    check("w_ready", w_ready, gw);
    check("r_ready", r_ready, gr);

    if (gw) begin
      check("wr_port", {mem_en, mem_wmode, mem_addr, mem_wmask}, {1'b1, 1'b1, w_addr, w_mask});
      check("wr_data", mem_wdata, w_data);
      for (int g = 0; g < MASK_W; g++)
        if (w_mask[g]) ref_mem[w_addr][g*GW +: GW] = w_data[g*GW +: GW];
      grants = {grants, "W"};
    end else if (gr) begin
      check("rd_port", {mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata},
            {1'b1, 1'b0, r_addr, 6'h00, 36'h0});
      exp_q.push_back(ref_mem[r_addr]);
      grants = {grants, "R"};
    end else begin
      check("idle_en", mem_en, 0);
      grants = {grants, "-"};
    end
    resp_due = gr;
    last_gw  = gw;
    last_gr  = gr;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    w_valid = 1'b1; w_addr = a; w_mask = m; w_data = d; r_valid = 1'b0;
    run_cycle();
    w_valid = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    r_valid = 1'b1; r_addr = a; w_valid = 1'b0;
    run_cycle();
    r_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r0;
    w_addr = '0; w_mask = '0; w_data = '0; r_addr = '0;
    resp_seen = 0; grants = ""; last_resp = '1;

    // 1: reset, then the full sweep with no requests
    do_reset();
    sweep(0, DEPTH);

    // 6: read the last entry straight after init
    last_resp = '1;
    rd(8'hFF);
    run_cycle();
    check("t6_resp", last_resp, 36'h0);

    // 2: full write then read of the same address
    wr(8'h12, 6'h3F, 36'hA_BCDE_F012);
    rd(8'h12);
    run_cycle();
    check("t2_resp", last_resp, 36'hA_BCDE_F012);

    // 3: single-granule write, then read back
    wr(8'h12, 6'b000001, 36'hF_FFFF_FFFF);
    rd(8'h12);
    run_cycle();
    check("t3_resp", last_resp, 36'hA_BCDE_F03F);

    // zero mask consumes the port but leaves the entry alone
    wr(8'h12, 6'h00, 36'h5_5555_5555);
    rd(8'h12);
    run_cycle();
    check("zero_mask", last_resp, 36'hA_BCDE_F03F);

    // 4: both sides valid for 6 cycles
    grants = ""; r0 = resp_seen;
    w_valid = 1'b1; w_addr = 8'h20; w_mask = 6'h3F; w_data = 36'h1_2345_6789;
    r_valid = 1'b1; r_addr = 8'h20;
    repeat (6) run_cycle();
    w_valid = 1'b0; r_valid = 1'b0;
    run_cycle();
    total++;
    assert (grants == "RWRWRW-") else begin
      bad++;
      $error("FAIL t4_order observed=%s expected=RWRWRW-", grants);
    end
    check("t4_pulses", resp_seen - r0, 3);

    // random traffic; payloads held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!w_valid || last_gw) begin
        w_valid = ($urandom_range(99, 0) < 60);
        w_addr  = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom_range(7, 0));
        w_mask  = 6'($urandom_range(63, 0));
        w_data  = {4'($urandom_range(15, 0)), 32'($urandom())};
      end
      if (!r_valid || last_gr) begin
        r_valid = ($urandom_range(99, 0) < 60);
        r_addr  = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom_range(7, 0));
      end
      run_cycle();
    end

    // reset in RUN right after a read grant: response must not appear
    rd(8'h03);
    do_reset();
    sweep(0, DEPTH);
    rd(8'h03);
    run_cycle();
    check("post_reset_read", last_resp, 36'h0);

    // 5: reset at sweep count 100, restart with a write held off the whole time
    do_reset();
    sweep(0, 100);
    do_reset();
    w_valid = 1'b1; w_addr = 8'h33; w_mask = 6'h3F; w_data = 36'h9_8765_4321;
    sweep(0, DEPTH);
    run_cycle();
    check("t5_held_write", last_gw, 1);
    w_valid = 1'b0;
    rd(8'h33);
    run_cycle();
    check("t5_resp", last_resp, 36'h9_8765_4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
